// File: rtl/ebox_mbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ebox_mbox_pkg
// Purpose  : Shared types for the EBOX-to-MBOX request block. Contains the
//            request FSM state encoding, the held MCL command, the MBOX data
//            width and small helpers that classify a held command.
// Revision : 1.0  initial release
// ============================================================================
package ebox_mbox_pkg;

  localparam int MBOX_DATA_W = 36;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_RDWAIT = 3'd2,
    S_PAUSE  = 3'd3,
    S_WRREQ  = 3'd4,
    S_WRWAIT = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  // MCL cycle qualifiers captured when a cycle request is accepted
  typedef struct packed {
    logic rd;
    logic wr;
    logic pause;
    logic fetch;
    logic ld_ar;
    logic ld_arx;
  } cmd_t;

  // An instruction fetch is a read of memory even without VMA_READ
  function automatic logic cmd_is_read(input cmd_t c);
    return c.rd | c.fetch;
  endfunction

  function automatic logic cmd_is_rpw(input cmd_t c);
    return cmd_is_read(c) & c.wr & c.pause;
  endfunction

endpackage : ebox_mbox_pkg
`default_nettype wire

// File: rtl/mbox_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mbox_timeout_ctr
// Purpose  : Cycle counter that measures how long the MBOX has been silent
//            in the current wait state. Saturates at the terminal count.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            clr  - restart the count at zero (state change)
//            en   - count this cycle
//            tc   - count has reached TIMEOUT_CYC-1
// Revision : 1.0  initial release
// ============================================================================
module mbox_timeout_ctr #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : mbox_timeout_ctr
`default_nettype wire

// File: rtl/ebox_mbox_req.sv
`default_nettype none
// ============================================================================
// Module   : ebox_mbox_req
// Purpose  : Runs the single outstanding EBOX memory transaction requested by
//            the MCL (read, write, read-pause-write, fetch), stalls the EBOX
//            clock while it is in flight, returns read data with AR/ARX load
//            strobes and reports page fail and MBOX timeout.
// Ports    : clk, RESET          - clock, synchronous active-high reset
//            cycReq, vma*, load* - MCL cycle request and qualifiers
//            vma                 - VMA bits 13:35
//            storeAR, arData     - write data from AR
//            mbox* (inputs)      - MBOX ack / read data / write done / PF
//            mboxReq/Rd/Wr/Rpw   - request to MBOX with held address/data
//            memWait             - EBOX clock stall
//            arLd, arxLd, rdData - read data and one-cycle load strobes
//            pageFail, nxmErr    - sticky error flags
// Revision : 1.0  initial release
// ============================================================================
module ebox_mbox_req
  import ebox_mbox_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int ADR_W       = 23
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   cycReq,
  input  logic                   vmaRead,
  input  logic                   vmaWrite,
  input  logic                   vmaPause,
  input  logic                   vmaFetch,
  input  logic                   loadAR,
  input  logic                   loadARX,
  input  logic [ADR_W-1:0]       vma,
  input  logic                   storeAR,
  input  logic [MBOX_DATA_W-1:0] arData,
  input  logic                   mboxAck,
  input  logic                   mboxXfer,
  input  logic [MBOX_DATA_W-1:0] mboxData,
  input  logic                   mboxWrDone,
  input  logic                   mboxPF,
  output logic                   mboxReq,
  output logic                   mboxRd,
  output logic                   mboxWr,
  output logic                   mboxRpw,
  output logic [ADR_W-1:0]       mboxAdr,
  output logic [MBOX_DATA_W-1:0] mboxWdata,
  output logic                   memWait,
  output logic                   arLd,
  output logic                   arxLd,
  output logic [MBOX_DATA_W-1:0] rdData,
  output logic                   pageFail,
  output logic                   nxmErr
);

  state_e                 state_q, state_d;
  cmd_t                   cmd_q, cmd_d;
  logic                   pend_q, pend_d;      // write-only request waiting for storeAR
  logic [ADR_W-1:0]       adr_q, adr_d;
  logic [MBOX_DATA_W-1:0] wdata_q, wdata_d;
  logic [MBOX_DATA_W-1:0] rdata_q, rdata_d;
  logic                   req_q, req_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic                   rpw_q, rpw_d;
  logic                   ar_ld_q, ar_ld_d;
  logic                   arx_ld_q, arx_ld_d;
  logic                   pf_q, pf_d;
  logic                   nxm_q, nxm_d;

  logic                   tmo_tc;
  logic                   tmo_en;
  logic                   tmo_clr;
  cmd_t                   new_cmd;
  logic                   new_wr_only;

  assign new_cmd = '{rd: vmaRead, wr: vmaWrite, pause: vmaPause, fetch: vmaFetch,
                     ld_ar: loadAR, ld_arx: loadARX};
  assign new_wr_only = vmaWrite && !(vmaRead || vmaFetch);

  assign tmo_en  = (state_q == S_REQ)   || (state_q == S_RDWAIT) ||
                   (state_q == S_WRREQ) || (state_q == S_WRWAIT);
  assign tmo_clr = (state_d != state_q);

  mbox_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk (clk),
    .rst (RESET),
    .clr (tmo_clr),
    .en  (tmo_en),
    .tc  (tmo_tc)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    pend_d   = pend_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ar_ld_d  = 1'b0;
    arx_ld_d = 1'b0;
    pf_d     = pf_q;
    nxm_d    = nxm_q;

    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          if (storeAR) begin
            wdata_d = arData;
            pend_d  = 1'b0;
            state_d = S_REQ;
          end
        end else if (cycReq) begin
          cmd_d = new_cmd;
          adr_d = vma;
          pf_d  = 1'b0;
          if (new_wr_only && !storeAR) begin
            pend_d = 1'b1;
          end else begin
            if (new_wr_only) begin
              wdata_d = arData;
            end
            state_d = S_REQ;
          end
        end
      end

      // Page fail outranks every MBOX response in the same cycle
      S_REQ: begin
        if (mboxPF) begin
          pf_d    = 1'b1;
          state_d = S_FAULT;
        end else if (mboxAck) begin
          state_d = cmd_is_read(cmd_q) ? S_RDWAIT : S_WRWAIT;
        end else if (tmo_tc) begin
          nxm_d   = 1'b1;
          state_d = S_FAULT;
        end
      end

      S_RDWAIT: begin
        if (mboxPF) begin
          pf_d    = 1'b1;
          state_d = S_FAULT;
        end else if (mboxXfer) begin
          rdata_d  = mboxData;
          // With neither load bit set the data still goes to AR
          ar_ld_d  = cmd_q.ld_ar | ~cmd_q.ld_arx;
          arx_ld_d = cmd_q.ld_arx;
          state_d  = cmd_is_rpw(cmd_q) ? S_PAUSE : S_IDLE;
        end else if (tmo_tc) begin
          nxm_d   = 1'b1;
          state_d = S_FAULT;
        end
      end

      S_PAUSE: begin
        if (storeAR) begin
          wdata_d = arData;
          state_d = S_WRREQ;
        end
      end

      S_WRREQ: begin
        if (mboxAck) begin
          state_d = S_WRWAIT;
        end else if (tmo_tc) begin
          nxm_d   = 1'b1;
          state_d = S_FAULT;
        end
      end

      S_WRWAIT: begin
        if (mboxPF) begin
          pf_d    = 1'b1;
          state_d = S_FAULT;
        end else if (mboxWrDone) begin
          state_d = S_IDLE;
        end else if (tmo_tc) begin
          nxm_d   = 1'b1;
          state_d = S_FAULT;
        end
      end

      S_FAULT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Request lines are registered from the next state so they change
    // cleanly on the edge that enters or leaves a request state
    req_d = (state_d == S_REQ) || (state_d == S_WRREQ);
    rd_d  = (state_d == S_REQ) && cmd_is_read(cmd_d);
    wr_d  = ((state_d == S_REQ) && cmd_d.wr && !cmd_is_read(cmd_d)) ||
            (state_d == S_WRREQ);
    rpw_d = (state_d == S_REQ) && cmd_is_rpw(cmd_d);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      pend_q   <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rpw_q    <= 1'b0;
      ar_ld_q  <= 1'b0;
      arx_ld_q <= 1'b0;
      pf_q     <= 1'b0;
      nxm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      pend_q   <= pend_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rpw_q    <= rpw_d;
      ar_ld_q  <= ar_ld_d;
      arx_ld_q <= arx_ld_d;
      pf_q     <= pf_d;
      nxm_q    <= nxm_d;
    end
  end

  assign memWait   = (state_q == S_REQ)   || (state_q == S_RDWAIT) ||
                     (state_q == S_WRREQ) || (state_q == S_WRWAIT) ||
                     ((state_q == S_IDLE) && pend_q);
  assign mboxReq   = req_q;
  assign mboxRd    = rd_q;
  assign mboxWr    = wr_q;
  assign mboxRpw   = rpw_q;
  assign mboxAdr   = adr_q;
  assign mboxWdata = wdata_q;
  assign arLd      = ar_ld_q;
  assign arxLd     = arx_ld_q;
  assign rdData    = rdata_q;
  assign pageFail  = pf_q;
  assign nxmErr    = nxm_q;

endmodule : ebox_mbox_req
`default_nettype wire

// File: tb/tb_ebox_mbox_req.sv
`default_nettype none
// ============================================================================
// Module   : tb_ebox_mbox_req
// Purpose  : Self-checking bench for ebox_mbox_req: directed scenarios plus
//            randomized transactions checked against a transaction-level
//            model of the expected MBOX request and EBOX-visible results.
// Revision : 1.0  initial release
// ============================================================================
module tb_ebox_mbox_req;

  logic        clk = 1'b0;
  logic        RESET;
  logic        cycReq, vmaRead, vmaWrite, vmaPause, vmaFetch, loadAR, loadARX;
  logic [22:0] vma;
  logic        storeAR;
  logic [35:0] arData;
  logic        mboxAck, mboxXfer, mboxWrDone, mboxPF;
  logic [35:0] mboxData;
  logic        mboxReq, mboxRd, mboxWr, mboxRpw, memWait, arLd, arxLd;
  logic        pageFail, nxmErr;
  logic [22:0] mboxAdr;
  logic [35:0] mboxWdata, rdData;

  int n_chk  = 0;
  int n_pass = 0;
  logic [35:0] m_rd = '0;   // model of the last successfully read word

  always #5 clk = ~clk;

  ebox_mbox_req #(.TIMEOUT_CYC(16), .ADR_W(23)) dut (
    .clk(clk), .RESET(RESET), .cycReq(cycReq), .vmaRead(vmaRead),
    .vmaWrite(vmaWrite), .vmaPause(vmaPause), .vmaFetch(vmaFetch),
    .loadAR(loadAR), .loadARX(loadARX), .vma(vma), .storeAR(storeAR),
    .arData(arData), .mboxAck(mboxAck), .mboxXfer(mboxXfer),
    .mboxData(mboxData), .mboxWrDone(mboxWrDone), .mboxPF(mboxPF),
    .mboxReq(mboxReq), .mboxRd(mboxRd), .mboxWr(mboxWr), .mboxRpw(mboxRpw),
    .mboxAdr(mboxAdr), .mboxWdata(mboxWdata), .memWait(memWait),
    .arLd(arLd), .arxLd(arxLd), .rdData(rdData), .pageFail(pageFail),
    .nxmErr(nxmErr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    cycReq = 0; vmaRead = 0; vmaWrite = 0; vmaPause = 0; vmaFetch = 0;
    loadAR = 0; loadARX = 0; vma = '0; storeAR = 0; arData = '0;
    mboxAck = 0; mboxXfer = 0; mboxData = '0; mboxWrDone = 0; mboxPF = 0;
  endtask

  task automatic test_reset();
    clr_in(); RESET = 1; step(); step();
    n_chk++;
    if ({mboxReq, mboxRd, mboxWr, mboxRpw, memWait, arLd, arxLd, pageFail, nxmErr} !== 9'b0)
      $display("FAIL reset_ctl: got %b want 0", {mboxReq, mboxRd, mboxWr, mboxRpw, memWait, arLd, arxLd, pageFail, nxmErr});
    else n_pass++;
    n_chk++;
    if ({mboxAdr, mboxWdata, rdData} !== '0)
      $display("FAIL reset_data: adr %h wdata %h rd %h want 0", mboxAdr, mboxWdata, rdData);
    else n_pass++;
    RESET = 0; step();
  endtask

  task automatic test_read();
    vma = 23'h00100; vmaRead = 1; loadAR = 1; cycReq = 1; step(); clr_in();
    n_chk++;
    if ({mboxReq, mboxRd, mboxWr, mboxRpw, memWait} !== 5'b11001 || mboxAdr !== 23'h00100)
      $display("FAIL read_req: got %b adr %h want 11001 adr 00100", {mboxReq, mboxRd, mboxWr, mboxRpw, memWait}, mboxAdr);
    else n_pass++;
    step(); mboxAck = 1; step(); mboxAck = 0;
    n_chk++;
    if ({mboxReq, memWait} !== 2'b01)
      $display("FAIL read_wait: req/wait %b want 01", {mboxReq, memWait});
    else n_pass++;
    step(); step();
    mboxXfer = 1; mboxData = 36'o123456701234; step(); clr_in();
    m_rd = 36'o123456701234;
    n_chk++;
    if ({arLd, arxLd, memWait} !== 3'b100 || rdData !== m_rd)
      $display("FAIL read_data: ar/arx/wait %b rd %o want 100 rd %o", {arLd, arxLd, memWait}, rdData, m_rd);
    else n_pass++;
    step();
    n_chk++;
    if ({arLd, arxLd, memWait} !== 3'b000)
      $display("FAIL read_strobe_len: ar/arx/wait %b want 000", {arLd, arxLd, memWait});
    else n_pass++;
  endtask

  task automatic test_rpw();
    vma = 23'h2ABCD; vmaRead = 1; vmaWrite = 1; vmaPause = 1; loadARX = 1;
    cycReq = 1; step(); clr_in();
    n_chk++;
    if ({mboxReq, mboxRd, mboxWr, mboxRpw} !== 4'b1101)
      $display("FAIL rpw_req: got %b want 1101", {mboxReq, mboxRd, mboxWr, mboxRpw});
    else n_pass++;
    mboxAck = 1; step(); clr_in();
    mboxXfer = 1; mboxData = 36'o444400001111; step(); clr_in();
    m_rd = 36'o444400001111;
    n_chk++;
    if ({arLd, arxLd, memWait, mboxReq} !== 4'b0100 || rdData !== m_rd)
      $display("FAIL rpw_read: ar/arx/wait/req %b rd %o want 0100 rd %o", {arLd, arxLd, memWait, mboxReq}, rdData, m_rd);
    else n_pass++;
    step();
    // a new cycle request while paused must be ignored
    cycReq = 1; vmaRead = 1; vma = 23'h00001; step(); clr_in();
    n_chk++;
    if ({memWait, mboxReq} !== 2'b00 || mboxAdr !== 23'h2ABCD)
      $display("FAIL rpw_pause: wait/req %b adr %h want 00 adr 2abcd", {memWait, mboxReq}, mboxAdr);
    else n_pass++;
    storeAR = 1; arData = 36'o777; step(); clr_in();
    n_chk++;
    if ({mboxReq, mboxRd, mboxWr, mboxRpw, memWait} !== 5'b10101 || mboxWdata !== 36'o777)
      $display("FAIL rpw_wrreq: got %b wdata %o want 10101 wdata 777", {mboxReq, mboxRd, mboxWr, mboxRpw, memWait}, mboxWdata);
    else n_pass++;
    mboxAck = 1; step(); clr_in();
    step(); mboxWrDone = 1; step(); clr_in();
    n_chk++;
    if ({mboxReq, memWait} !== 2'b00)
      $display("FAIL rpw_done: req/wait %b want 00", {mboxReq, memWait});
    else n_pass++;
  endtask

  task automatic test_write_delayed();
    vma = 23'h00555; vmaWrite = 1; cycReq = 1; step(); clr_in();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({mboxReq, memWait} !== 2'b01)
        $display("FAIL wr_pending: cycle %0d req/wait %b want 01", k, {mboxReq, memWait});
      else n_pass++;
      step();
    end
    storeAR = 1; arData = 36'o123; step(); clr_in();
    n_chk++;
    if ({mboxReq, mboxRd, mboxWr, mboxRpw, memWait} !== 5'b10101 || mboxWdata !== 36'o123 || mboxAdr !== 23'h00555)
      $display("FAIL wr_req: got %b wdata %o adr %h want 10101 123 00555", {mboxReq, mboxRd, mboxWr, mboxRpw, memWait}, mboxWdata, mboxAdr);
    else n_pass++;
    mboxAck = 1; step(); clr_in();
    mboxWrDone = 1; step(); clr_in();
    n_chk++;
    if ({mboxReq, memWait} !== 2'b00)
      $display("FAIL wr_done: req/wait %b want 00", {mboxReq, memWait});
    else n_pass++;
  endtask

  task automatic test_pagefail();
    vma = 23'h00042; vmaRead = 1; loadAR = 1; cycReq = 1; step(); clr_in();
    mboxAck = 1; step(); clr_in();
    mboxXfer = 1; mboxPF = 1; mboxData = 36'o1; step(); clr_in();
    n_chk++;
    if ({pageFail, arLd, arxLd, mboxReq, memWait} !== 5'b10000 || rdData !== m_rd)
      $display("FAIL pf_xfer: pf/ar/arx/req/wait %b rd %o want 10000 rd %o", {pageFail, arLd, arxLd, mboxReq, memWait}, rdData, m_rd);
    else n_pass++;
    step();
    n_chk++;
    if ({pageFail, memWait, arLd} !== 3'b100)
      $display("FAIL pf_sticky: pf/wait/ar %b want 100", {pageFail, memWait, arLd});
    else n_pass++;
    vma = 23'h00009; vmaWrite = 1; storeAR = 1; arData = 36'o5; cycReq = 1; step(); clr_in();
    n_chk++;
    if ({pageFail, mboxReq, mboxWr} !== 3'b011)
      $display("FAIL pf_clear: pf/req/wr %b want 011", {pageFail, mboxReq, mboxWr});
    else n_pass++;
    mboxAck = 1; mboxPF = 1; step(); clr_in();
    n_chk++;
    if ({pageFail, mboxReq, memWait} !== 3'b100)
      $display("FAIL pf_ack: pf/req/wait %b want 100", {pageFail, mboxReq, memWait});
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    logic        rd, wr, pause, fetch, la, lx, e_rd, e_wo, e_rpw, e_ar;
    logic [22:0] a;
    logic [35:0] rdat, wdat;
    int          kind, pf_at, sd;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      la = 1'($urandom); lx = 1'($urandom);
      if (kind == 0) begin
        rd = 1; wr = 0; pause = 1'($urandom); fetch = 1'($urandom);
      end else if (kind == 1) begin
        rd = 0; fetch = 0; wr = 1; pause = 1'($urandom);
      end else begin
        rd = 1'($urandom); fetch = rd ? 1'($urandom) : 1'b1; wr = 1; pause = 1;
      end
      a    = 23'($urandom);
      rdat = {4'($urandom), 32'($urandom)};
      wdat = {4'($urandom), 32'($urandom)};
      // Transaction model: what the MBOX should see and what the EBOX gets
      e_rd  = rd | fetch;
      e_wo  = wr & ~e_rd;
      e_rpw = e_rd & wr & pause;
      if (la) e_ar = 1; else if (lx) e_ar = 0; else e_ar = 1;
      pf_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
      sd    = e_wo ? $urandom_range(0, 3) : 0;

      cycReq = 1; vmaRead = rd; vmaWrite = wr; vmaPause = pause; vmaFetch = fetch;
      loadAR = la; loadARX = lx; vma = a; storeAR = e_wo && (sd == 0); arData = wdat;
      step(); clr_in(); vma = 23'($urandom);
      n_chk++;
      if ({pageFail, nxmErr} !== 2'b00)
        $display("FAIL rnd_accept t%0d: pf/nxm %b want 00", t, {pageFail, nxmErr});
      else n_pass++;
      if (e_wo && sd > 0) begin
        for (int k = 0; k < sd; k++) begin
          n_chk++;
          if ({mboxReq, memWait} !== 2'b01)
            $display("FAIL rnd_pending t%0d: req/wait %b want 01", t, {mboxReq, memWait});
          else n_pass++;
          step();
        end
        storeAR = 1; arData = wdat; step(); clr_in();
      end
      n_chk++;
      if ({mboxReq, mboxRd, mboxWr, mboxRpw, memWait} !== {1'b1, e_rd, e_wo, e_rpw, 1'b1} || mboxAdr !== a ||
          (e_wo && mboxWdata !== wdat))
        $display("FAIL rnd_req t%0d: got %b adr %h wd %h want %b adr %h wd %h", t,
                 {mboxReq, mboxRd, mboxWr, mboxRpw, memWait}, mboxAdr, mboxWdata, {1'b1, e_rd, e_wo, e_rpw, 1'b1}, a, wdat);
      else n_pass++;
      repeat ($urandom_range(0, 4)) step();
      mboxAck = 1; mboxPF = (pf_at == 1); step(); clr_in();
      if (pf_at == 1) begin
        n_chk++;
        if ({pageFail, mboxReq, memWait, arLd, arxLd} !== 5'b10000)
          $display("FAIL rnd_pf_ack t%0d: got %b want 10000", t, {pageFail, mboxReq, memWait, arLd, arxLd});
        else n_pass++;
        step();
      end else if (e_rd) begin
        repeat ($urandom_range(0, 4)) step();
        mboxXfer = 1; mboxData = rdat; mboxPF = (pf_at == 2); step(); clr_in();
        if (pf_at == 2) begin
          n_chk++;
          if ({pageFail, arLd, arxLd, memWait, mboxReq} !== 5'b10000 || rdData !== m_rd)
            $display("FAIL rnd_pf_xfer t%0d: got %b rd %h want 10000 rd %h", t, {pageFail, arLd, arxLd, memWait, mboxReq}, rdData, m_rd);
          else n_pass++;
          step();
        end else begin
          m_rd = rdat;
          n_chk++;
          if ({arLd, arxLd, memWait} !== {e_ar, lx, 1'b0} || rdData !== m_rd)
            $display("FAIL rnd_xfer t%0d: ar/arx/wait %b rd %h want %b rd %h", t, {arLd, arxLd, memWait}, rdData, {e_ar, lx, 1'b0}, m_rd);
          else n_pass++;
          step();
          if (e_rpw) begin
            cycReq = 1; vma = 23'($urandom);
            repeat ($urandom_range(0, 3)) step();
            clr_in();
            n_chk++;
            if ({memWait, mboxReq, arLd} !== 3'b000 || mboxAdr !== a)
              $display("FAIL rnd_pause t%0d: wait/req/ar %b adr %h want 000 adr %h", t, {memWait, mboxReq, arLd}, mboxAdr, a);
            else n_pass++;
            storeAR = 1; arData = wdat; step(); clr_in();
            n_chk++;
            if ({mboxReq, mboxRd, mboxWr, mboxRpw, memWait} !== 5'b10101 || mboxWdata !== wdat)
              $display("FAIL rnd_wrreq t%0d: got %b wd %h want 10101 wd %h", t, {mboxReq, mboxRd, mboxWr, mboxRpw, memWait}, mboxWdata, wdat);
            else n_pass++;
            repeat ($urandom_range(0, 3)) step();
            mboxAck = 1; step(); clr_in();
            repeat ($urandom_range(0, 3)) step();
            mboxWrDone = 1; step(); clr_in();
            n_chk++;
            if ({mboxReq, memWait, pageFail} !== 3'b000)
              $display("FAIL rnd_rpw_done t%0d: req/wait/pf %b want 000", t, {mboxReq, memWait, pageFail});
            else n_pass++;
          end
        end
      end else begin
        repeat ($urandom_range(0, 4)) step();
        if (pf_at == 2) mboxPF = 1; else mboxWrDone = 1;
        step(); clr_in();
        n_chk++;
        if ({pageFail, memWait, mboxReq} !== {(pf_at == 2), 2'b00})
          $display("FAIL rnd_wr_done t%0d: pf/wait/req %b want %b", t, {pageFail, memWait, mboxReq}, {(pf_at == 2), 2'b00});
        else n_pass++;
        if (pf_at == 2) step();
      end
    end
  endtask

  task automatic test_timeout();
    vma = 23'h01234; vmaRead = 1; cycReq = 1; step(); clr_in();
    repeat (15) step();
    n_chk++;
    if ({mboxReq, nxmErr, memWait} !== 3'b101)
      $display("FAIL tmo_16th: req/nxm/wait %b want 101", {mboxReq, nxmErr, memWait});
    else n_pass++;
    step();
    n_chk++;
    if ({mboxReq, nxmErr, memWait, pageFail} !== 4'b0100)
      $display("FAIL tmo_fire: req/nxm/wait/pf %b want 0100", {mboxReq, nxmErr, memWait, pageFail});
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    vma = 23'h00777; vmaWrite = 1; storeAR = 1; arData = 36'o55; cycReq = 1; step(); clr_in();
    mboxAck = 1; step(); clr_in();
    n_chk++;
    if ({memWait, mboxReq, nxmErr} !== 3'b101)
      $display("FAIL rstmid_wrwait: wait/req/nxm %b want 101", {memWait, mboxReq, nxmErr});
    else n_pass++;
    RESET = 1; step();
    m_rd = '0;
    n_chk++;
    if ({mboxReq, mboxRd, mboxWr, mboxRpw, memWait, arLd, arxLd, pageFail, nxmErr} !== 9'b0 ||
        {mboxAdr, mboxWdata, rdData} !== '0)
      $display("FAIL rstmid_clear: ctl %b adr %h wd %h rd %h want 0",
               {mboxReq, mboxRd, mboxWr, mboxRpw, memWait, arLd, arxLd, pageFail, nxmErr}, mboxAdr, mboxWdata, rdData);
    else n_pass++;
    RESET = 0; step();
    n_chk++;
    if ({memWait, mboxReq} !== 2'b00)
      $display("FAIL rstmid_idle: wait/req %b want 00", {memWait, mboxReq});
    else n_pass++;
  endtask

  initial begin
    RESET = 1;
    clr_in();
    test_reset();
    test_read();
    test_rpw();
    test_write_delayed();
    test_pagefail();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_ebox_mbox_req
`default_nettype wire
